// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: channel opcodes, responder FSM states and
// the request legality check used when an A beat is accepted.
package tl_pkg;

   localparam logic [2:0] TL_PUT_FULL    = 3'd0;
   localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] TL_GET         = 3'd4;

   localparam logic [2:0] TL_ACK         = 3'd0;
   localparam logic [2:0] TL_ACK_DATA    = 3'd1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } tl_state_e;

   // True when a request falls outside the window, is oversized, misaligned
   // or carries an opcode this responder does not serve. The upper bound is
   // formed in 65 bits so a window ending at the top of the address space
   // does not wrap.
   function automatic logic tl_denied(
      input logic [2:0]  opcode,
      input logic [2:0]  size,
      input logic [63:0] addr,
      input logic [63:0] base,
      input int unsigned depth_log2
   );
      logic [64:0] limit;
      logic [63:0] align_mask;
      logic        bad_range;
      logic        bad_size;
      logic        bad_align;
      logic        bad_opcode;
      limit      = {1'b0, base} + (65'd8 << depth_log2);
      align_mask = (64'd1 << size) - 64'd1;
      bad_range  = (addr < base) || ({1'b0, addr} >= limit);
      bad_size   = (size > 3'd3);
      bad_align  = ((addr & align_mask) != 64'd0);
      bad_opcode = !((opcode == TL_GET) || (opcode == TL_PUT_FULL) ||
                     (opcode == TL_PUT_PARTIAL));
      return bad_range || bad_size || bad_align || bad_opcode;
   endfunction

endpackage

// File: rtl/tilelink_if.sv
// TileLink-UL A/D channel bundle between an initiator and a responder.
interface tilelink;
   logic [2:0]  a_opcode;
   logic [2:0]  a_param;
   logic [2:0]  a_size;
   logic [3:0]  a_source;
   logic [63:0] a_address;
   logic [7:0]  a_mask;
   logic [63:0] a_data;
   logic        a_corrupt;
   logic        a_valid;
   logic        a_ready;

   logic [2:0]  d_opcode;
   logic [1:0]  d_param;
   logic [2:0]  d_size;
   logic [3:0]  d_source;
   logic [5:0]  d_sink;
   logic        d_denied;
   logic [63:0] d_data;
   logic        d_corrupt;
   logic        d_valid;
   logic        d_ready;

   modport slave (
      input  a_opcode, a_param, a_size, a_source, a_address, a_mask,
             a_data, a_corrupt, a_valid, d_ready,
      output a_ready, d_opcode, d_param, d_size, d_source, d_sink,
             d_denied, d_data, d_corrupt, d_valid
   );
endinterface

// File: rtl/tl_sram.sv
// Single-port 64-bit RAM with per-byte write enables and a registered read.
// rdata only changes on an enabled read, so it holds the last word read
// until the next access.
module tl_sram #(
   parameter int unsigned DEPTH_LOG2 = 14
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic [7:0]            we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [63:0]           wdata,
   output logic [63:0]           rdata
);

   logic [63:0] mem [0:(1 << DEPTH_LOG2) - 1];

   // Byte-masked write, or whole-word read when no byte enable is set.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int b = 0; b < 8; b++) begin
            if (we[b]) begin
               mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
         if (we == 8'h00) begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/tl_mem_responder.sv
// TileLink-UL memory responder: serves Get/PutFullData/PutPartialData from
// an internal RAM, one transaction at a time, with D-channel backpressure.
//
// state    | meaning
// S_IDLE   | a_ready high, waiting for an A beat
// S_ACCESS | request latched, RAM read or write in flight this cycle
// S_RESP   | D beat presented, held until d_ready
module tl_mem_responder #(
   parameter logic [63:0] BASE       = 64'h0000_0000_8000_0000,
   parameter int unsigned DEPTH_LOG2 = 14,
   parameter logic [5:0]  SINK_ID    = 6'h0
) (
   input logic    clk,
   input logic    rst_n,
   tilelink.slave bus
);

   import tl_pkg::*;

   tl_state_e             state_q;
   tl_state_e             state_d;

   logic                  a_ready_w;
   logic                  a_fire;

   logic [2:0]            opc_q;
   logic [2:0]            size_q;
   logic [3:0]            src_q;
   logic [63:0]           addr_q;
   logic [7:0]            mask_q;
   logic [63:0]           data_q;
   logic                  corrupt_q;
   logic                  denied_q;

   logic                  is_get;
   logic                  is_put;
   logic                  good_get;
   logic                  good_put;
   logic [63:0]           addr_off;
   logic [DEPTH_LOG2-1:0] word_idx;

   logic                  sram_en;
   logic [7:0]            sram_we;
   logic [63:0]           sram_rdata;

   logic                  unused_bits;

   assign a_fire      = bus.a_valid & a_ready_w;
   assign unused_bits = ^{bus.a_param, addr_off};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: accept, one access cycle, then hold the response until taken.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (a_fire) state_d = S_ACCESS;
         S_ACCESS: state_d = S_RESP;
         S_RESP:   if (bus.d_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Capture the A beat and its legality verdict on acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opc_q     <= 3'd0;
         size_q    <= 3'd0;
         src_q     <= 4'd0;
         addr_q    <= 64'd0;
         mask_q    <= 8'd0;
         data_q    <= 64'd0;
         corrupt_q <= 1'b0;
         denied_q  <= 1'b0;
      end else if (a_fire) begin
         opc_q     <= bus.a_opcode;
         size_q    <= bus.a_size;
         src_q     <= bus.a_source;
         addr_q    <= bus.a_address;
         mask_q    <= bus.a_mask;
         data_q    <= bus.a_data;
         corrupt_q <= bus.a_corrupt;
         denied_q  <= tl_denied(bus.a_opcode, bus.a_size, bus.a_address,
                                BASE, DEPTH_LOG2);
      end
   end

   // Decode of the latched request; corrupt Puts are acknowledged but never
   // reach the RAM.
   always_comb begin
      addr_off = addr_q - BASE;
      word_idx = addr_off[3 +: DEPTH_LOG2];
      is_get   = (opc_q == TL_GET);
      is_put   = (opc_q == TL_PUT_FULL) || (opc_q == TL_PUT_PARTIAL);
      good_get = is_get & ~denied_q;
      good_put = is_put & ~denied_q & ~corrupt_q;
   end

   // Outputs: RAM strobes during S_ACCESS, D fields only while in S_RESP so
   // completion and reset both return every D field to zero.
   always_comb begin
      a_ready_w     = (state_q == S_IDLE);
      sram_en       = 1'b0;
      sram_we       = 8'h00;
      bus.d_valid   = 1'b0;
      bus.d_opcode  = 3'd0;
      bus.d_param   = 2'd0;
      bus.d_size    = 3'd0;
      bus.d_source  = 4'd0;
      bus.d_sink    = 6'd0;
      bus.d_denied  = 1'b0;
      bus.d_data    = 64'd0;
      bus.d_corrupt = 1'b0;
      case (state_q)
         S_ACCESS: begin
            sram_en = good_get | good_put;
            sram_we = good_put ? mask_q : 8'h00;
         end
         S_RESP: begin
            bus.d_valid   = 1'b1;
            bus.d_opcode  = is_get ? TL_ACK_DATA : TL_ACK;
            bus.d_size    = size_q;
            bus.d_source  = src_q;
            bus.d_sink    = SINK_ID;
            bus.d_denied  = denied_q;
            bus.d_data    = good_get ? sram_rdata : 64'd0;
            bus.d_corrupt = denied_q & is_get;
         end
         default: ;
      endcase
   end

   assign bus.a_ready = a_ready_w;

   tl_sram #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_sram (
      .clk   (clk),
      .en    (sram_en),
      .we    (sram_we),
      .addr  (word_idx),
      .wdata (data_q),
      .rdata (sram_rdata)
   );

endmodule

// File: tb/tb_tl_mem_responder.sv
// Directed bench for tl_mem_responder: a driver issues A beats and queues the
// expected D beat; a negedge monitor pops and compares each completed D beat.
module tb_tl_mem_responder;

   import tl_pkg::*;

   typedef struct packed {
      logic [2:0]  op;
      logic [2:0]  size;
      logic [3:0]  src;
      logic        den;
      logic [63:0] data;
      logic        cor;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   errors;
   int   checks;
   int   fire_cyc;
   exp_t sb[$];

   tilelink bus_if ();

   tl_mem_responder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                        input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data,
                        input logic cor, input logic push, input logic [2:0] e_op,
                        input logic e_den, input logic [63:0] e_data, input logic e_cor);
      int   n;
      exp_t e;
      @(posedge clk); #1;
      bus_if.a_opcode  = op;
      bus_if.a_param   = 3'd0;
      bus_if.a_size    = sz;
      bus_if.a_source  = src;
      bus_if.a_address = addr;
      bus_if.a_mask    = mask;
      bus_if.a_data    = data;
      bus_if.a_corrupt = cor;
      bus_if.a_valid   = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (bus_if.a_ready || n > 50) break;
         n++;
      end
      if (!bus_if.a_ready) begin
         chk("a_ready_timeout", 96'd0, 96'd1);
         bus_if.a_valid = 1'b0;
         return;
      end
      fire_cyc = cyc;
      if (push) begin
         e.op   = e_op;
         e.size = sz;
         e.src  = src;
         e.den  = e_den;
         e.data = e_data;
         e.cor  = e_cor;
         e.cyc  = cyc + 2;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      bus_if.a_valid = 1'b0;
   endtask

   task automatic put(input logic [2:0] op, input logic [63:0] addr, input logic [7:0] mask,
                      input logic [63:0] data, input logic [3:0] src, input logic e_den);
      issue(op, 3'd3, src, addr, mask, data, 1'b0, 1'b1, TL_ACK, e_den, 64'd0, 1'b0);
   endtask

   task automatic get(input logic [63:0] addr, input logic [3:0] src, input logic [63:0] e_data);
      issue(TL_GET, 3'd3, src, addr, 8'hFF, 64'd0, 1'b0, 1'b1, TL_ACK_DATA, 1'b0, e_data, 1'b0);
   endtask

   task automatic get_denied(input logic [63:0] addr, input logic [3:0] src);
      issue(TL_GET, 3'd3, src, addr, 8'hFF, 64'd0, 1'b0, 1'b1, TL_ACK_DATA, 1'b1, 64'd0, 1'b1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(sb.size() == 0 && bus_if.a_ready) && n <= 60) begin
         @(negedge clk);
         n++;
      end
      if (n > 60) chk("drain_timeout", 96'd0, 96'd1);
   endtask

   // Monitor: latency on first sight of a D beat, field stability while
   // stalled, full comparison on the D-fire.
   logic        in_resp;
   logic        held;
   logic [83:0] snap;
   logic [83:0] dvec;
   exp_t        ex;

   assign dvec = {bus_if.d_opcode, bus_if.d_param, bus_if.d_size, bus_if.d_source,
                  bus_if.d_sink, bus_if.d_denied, bus_if.d_data, bus_if.d_corrupt};

   always @(negedge clk) begin
      if (!rst_n) begin
         in_resp = 1'b0;
         held    = 1'b0;
      end else if (bus_if.d_valid) begin
         chk("a_ready_low_during_resp", {95'd0, bus_if.a_ready}, 96'd0);
         if (held) chk("d_stable_while_stalled", {12'd0, dvec}, {12'd0, snap});
         if (!in_resp) begin
            in_resp = 1'b1;
            if (sb.size() == 0) chk("unexpected_d_beat", 96'd1, 96'd0);
            else chk("d_valid_latency", 96'(cyc), 96'(sb[0].cyc));
         end
         if (bus_if.d_ready) begin
            held    = 1'b0;
            in_resp = 1'b0;
            if (sb.size() != 0) begin
               ex = sb.pop_front();
               chk("d_opcode",  96'(bus_if.d_opcode),  96'(ex.op));
               chk("d_param",   96'(bus_if.d_param),   96'd0);
               chk("d_size",    96'(bus_if.d_size),    96'(ex.size));
               chk("d_source",  96'(bus_if.d_source),  96'(ex.src));
               chk("d_sink",    96'(bus_if.d_sink),    96'd0);
               chk("d_denied",  96'(bus_if.d_denied),  96'(ex.den));
               chk("d_data",    96'(bus_if.d_data),    96'(ex.data));
               chk("d_corrupt", 96'(bus_if.d_corrupt), 96'(ex.cor));
            end
         end else begin
            held = 1'b1;
            snap = dvec;
         end
      end else begin
         held = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int prev;
      errors = 0;
      checks = 0;
      cyc    = 0;
      rst_n  = 1'b0;
      bus_if.a_valid   = 1'b0;
      bus_if.a_opcode  = 3'd0;
      bus_if.a_param   = 3'd0;
      bus_if.a_size    = 3'd0;
      bus_if.a_source  = 4'd0;
      bus_if.a_address = 64'd0;
      bus_if.a_mask    = 8'd0;
      bus_if.a_data    = 64'd0;
      bus_if.a_corrupt = 1'b0;
      bus_if.d_ready   = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_d_valid", {95'd0, bus_if.d_valid}, 96'd0);
      chk("reset_d_fields", {12'd0, dvec}, 96'd0);
      chk("reset_a_ready", {95'd0, bus_if.a_ready}, 96'd1);
      rst_n = 1'b1;

      // Full write then read back; partial write merges low bytes.
      put(TL_PUT_FULL, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 4'd3, 1'b0);
      get(64'h8000_0010, 4'd5, 64'h1122_3344_5566_7788);
      put(TL_PUT_PARTIAL, 64'h8000_0010, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 4'd1, 1'b0);
      get(64'h8000_0010, 4'd2, 64'h1122_3344_BBBB_BBBB);

      // Window edges, misalignment, illegal opcode, corrupt Put.
      put(TL_PUT_FULL, 64'h8000_0000, 8'hFF, 64'h0123_4567_89AB_CDEF, 4'd4, 1'b0);
      get_denied(64'h7FFF_FFF8, 4'd6);
      get_denied(64'h8000_0004, 4'd7);
      put(TL_PUT_FULL, 64'h8002_0000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 1'b1);
      get(64'h8000_0000, 4'd9, 64'h0123_4567_89AB_CDEF);
      issue(3'd2, 3'd3, 4'd10, 64'h8000_0000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
            1'b1, TL_ACK, 1'b1, 64'd0, 1'b0);
      issue(TL_PUT_FULL, 3'd3, 4'd11, 64'h8000_0010, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD, 1'b1,
            1'b1, TL_ACK, 1'b0, 64'd0, 1'b0);
      get(64'h8000_0010, 4'd12, 64'h1122_3344_BBBB_BBBB);
      issue(TL_PUT_PARTIAL, 3'd2, 4'd13, 64'h8000_0004, 8'hF0, 64'h5555_5555_0000_0000, 1'b0,
            1'b1, TL_ACK, 1'b0, 64'd0, 1'b0);
      get(64'h8000_0000, 4'd14, 64'h5555_5555_89AB_CDEF);
      put(TL_PUT_FULL, 64'h8001_FFF8, 8'hFF, 64'hDEAD_BEEF_0000_0001, 4'd15, 1'b0);
      get(64'h8001_FFF8, 4'd0, 64'hDEAD_BEEF_0000_0001);
      wait_idle();

      // Backpressure: d_ready low for five D cycles.
      @(posedge clk); #1;
      bus_if.d_ready = 1'b0;
      get(64'h8000_0010, 4'd6, 64'h1122_3344_BBBB_BBBB);
      n = 0;
      while (!bus_if.d_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("stall_d_valid_seen", {95'd0, bus_if.d_valid}, 96'd1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("stall_a_ready", {95'd0, bus_if.a_ready}, 96'd0);
      end
      @(posedge clk); #1;
      bus_if.d_ready = 1'b1;
      @(negedge clk);
      chk("stall_d_valid_before_fire", {95'd0, bus_if.d_valid}, 96'd1);
      @(negedge clk);
      chk("stall_a_ready_after", {95'd0, bus_if.a_ready}, 96'd1);
      chk("stall_d_valid_after", {95'd0, bus_if.d_valid}, 96'd0);
      chk("stall_d_cleared", {12'd0, dvec}, 96'd0);
      wait_idle();

      // Back-to-back Gets from four sources.
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         get(64'h8000_0010, 4'(i), 64'h1122_3344_BBBB_BBBB);
         if (i > 0) chk("b2b_spacing", 96'(fire_cyc - prev), 96'd3);
         prev = fire_cyc;
      end
      wait_idle();

      // Reset during S_ACCESS of a Put drops the write.
      put(TL_PUT_FULL, 64'h8000_0020, 8'hFF, 64'hCAFE_F00D_1234_5678, 4'd2, 1'b0);
      wait_idle();
      issue(TL_PUT_FULL, 3'd3, 4'd3, 64'h8000_0020, 8'hFF, 64'h0BAD_0BAD_0BAD_0BAD, 1'b0,
            1'b0, TL_ACK, 1'b0, 64'd0, 1'b0);
      chk("rst_pre_state_access", 96'(dut.state_q), 96'(S_ACCESS));
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_d_valid", {95'd0, bus_if.d_valid}, 96'd0);
      chk("rst_d_fields", {12'd0, dvec}, 96'd0);
      chk("rst_state_idle", 96'(dut.state_q), 96'(S_IDLE));
      @(posedge clk); #1;
      rst_n = 1'b1;
      get(64'h8000_0020, 4'd4, 64'hCAFE_F00D_1234_5678);
      wait_idle();

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
